axi_wr_rr_scheduler: RTL and testbench
======================================

AXI_WR_RR_SCHEDULER -- requirements
Module: axi_wr_rr_scheduler

Interface
REQ-001 SHALL have parameter M_WIDTH, default 2, master-select width; N = 2**M_WIDTH masters.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of accepted-but-unresponded write bursts (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port MASTER_WR_ADDR_VALID, input, N, per-master AWVALID request.
REQ-006 SHALL have ports BUS_WR_ADDR_VALID and BUS_WR_ADDR_READY, input, 1 each, the muxed AW handshake.
REQ-007 SHALL have ports BUS_WR_DATA_VALID, BUS_WR_DATA_READY and BUS_WR_DATA_LAST, input, 1 each, the muxed W handshake.
REQ-008 SHALL have ports BUS_WR_BACK_VALID and BUS_WR_BACK_READY, input, 1 each, the B handshake.
REQ-009 SHALL have ports wr_addr_master_sel and wr_data_master_sel, output, M_WIDTH each, registered master selects.
REQ-010 SHALL have port wr_grant_valid, output, 1, high while AW of the selected master may pass.
REQ-011 SHALL have port wr_data_open, output, 1, high while W of the selected master may pass.
REQ-012 SHALL have port wr_outstanding, output, 8, the current outstanding burst count.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR and DATA, held in a register.
REQ-014 IDLE->ADDR SHALL occur when any request bit is set and wr_outstanding < MAX_OUTSTANDING; the winner is registered into both selects on the same edge, giving 1-cycle grant latency.
REQ-015 The winner SHALL be chosen round-robin: search starts at last_grant+1 modulo N, wraps, and takes the first set bit.
REQ-016 last_grant SHALL update only on an IDLE->ADDR transition.
REQ-017 ADDR: wr_grant_valid=1; on AW handshake (BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY) the FSM SHALL go to DATA.
REQ-018 DATA: wr_data_open=1 and wr_grant_valid=0; on W handshake with BUS_WR_DATA_LAST the FSM SHALL go to IDLE.
REQ-019 W beats SHALL pass only in DATA; W-before-AW SHALL be back-pressured upstream, not tracked here.
REQ-020 Selects SHALL remain stable from ADDR entry until DATA exit, regardless of request changes, including deassertion of the granted request.
REQ-021 wr_outstanding SHALL increment on AW handshake, decrement on B handshake, stay unchanged when both occur in one cycle, saturate at MAX_OUTSTANDING, and never underflow (a B handshake at 0 is ignored).
REQ-022 At wr_outstanding == MAX_OUTSTANDING the FSM SHALL stay in IDLE and grant nothing; a B handshake in that cycle permits a grant on the next edge (counter compared registered).
REQ-023 Back-to-back bursts SHALL be supported: DATA->IDLE->ADDR, with a minimum 1 idle cycle between bursts.
REQ-024 Bus-side handshakes SHALL be ignored when not in the consuming state (AW outside ADDR, W outside DATA).

Reset
REQ-025 On rstn low, asynchronously: state=IDLE, selects=0, last_grant=N-1 (first search starts at master 0), wr_grant_valid=0, wr_data_open=0, wr_outstanding=0.
REQ-026 Reset mid-burst SHALL abandon the burst; after release, behaviour SHALL be as from power-up.

Structure
REQ-027 The state enum (IDLE/ADDR/DATA) SHALL live in shared package axi_bus_pkg, alongside the AXI response-code constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_pick (inputs req[N], last[M_WIDTH]; outputs gnt_idx, any), combinational.

Verification (M_WIDTH=2, MAX_OUTSTANDING=2)
REQ-029 Requests 4'b1111 held, every burst 1 beat, B returned immediately -> grant order 0,1,2,3,0.
REQ-030 Master 2 granted, request dropped in ADDR, then 4-beat W with LAST on beat 4 -> selects stay 2 throughout; IDLE after beat 4.
REQ-031 Two AW accepted, no B -> wr_outstanding=2, no third grant; a single B -> grant on next edge, count 1 then 2.
REQ-032 AW and B handshakes in the same cycle at count 1 -> count remains 1.
REQ-033 rstn asserted during DATA beat 2 -> all outputs 0 immediately; first grant after release goes to the lowest requesting master.
REQ-034 W handshake with LAST while in ADDR -> ignored; the FSM stays in ADDR.

Source files
------------

// File: rtl/axi_bus_pkg.sv
// Shared AXI bus definitions: write-scheduler FSM states and AXI response codes.
package axi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wr_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping,
// with 'last' itself checked at the lowest priority.
module rr_pick #(
    parameter int M_WIDTH = 2
) (
    input  logic [2**M_WIDTH-1:0] req,
    input  logic [M_WIDTH-1:0]    last,
    output logic [M_WIDTH-1:0]    gnt_idx,
    output logic                  any
);

    localparam int N = 2**M_WIDTH;

    // rot_req[k] is the request of master last+k+1 (mod N), so index 0 has top priority.
    logic [N-1:0] rot_req;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_req[gi] = req[last + M_WIDTH'(gi + 1)];
    end

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                gnt_idx = last + M_WIDTH'(k + 1);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_rr_scheduler.sv
// AXI write-channel scheduler: round-robin AW grant, W window locked to the
// granted master until LAST, and an outstanding-burst limit tracked via B.
module axi_wr_rr_scheduler
    import axi_bus_pkg::*;
#(
    parameter int M_WIDTH         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2**M_WIDTH-1:0] MASTER_WR_ADDR_VALID,
    input  logic                  BUS_WR_ADDR_VALID,
    input  logic                  BUS_WR_ADDR_READY,
    input  logic                  BUS_WR_DATA_VALID,
    input  logic                  BUS_WR_DATA_READY,
    input  logic                  BUS_WR_DATA_LAST,
    input  logic                  BUS_WR_BACK_VALID,
    input  logic                  BUS_WR_BACK_READY,
    output logic [M_WIDTH-1:0]    wr_addr_master_sel,
    output logic [M_WIDTH-1:0]    wr_data_master_sel,
    output logic                  wr_grant_valid,
    output logic                  wr_data_open,
    output logic [7:0]            wr_outstanding
);

    localparam logic [7:0] MAX_Q = 8'(MAX_OUTSTANDING);

    wr_state_e          state_q;
    logic [M_WIDTH-1:0] addr_sel_q;
    logic [M_WIDTH-1:0] data_sel_q;
    logic [M_WIDTH-1:0] last_q;
    logic               grant_q;
    logic               open_q;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;

    logic [M_WIDTH-1:0] pick_idx;
    logic               pick_any;
    logic               aw_hs;
    logic               w_last_hs;
    logic               b_hs;

    rr_pick #(
        .M_WIDTH (M_WIDTH)
    ) u_pick (
        .req     (MASTER_WR_ADDR_VALID),
        .last    (last_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Bus handshakes only count in the state that consumes them.
    assign aw_hs     = (state_q == ADDR) && BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY;
    assign w_last_hs = (state_q == DATA) && BUS_WR_DATA_VALID && BUS_WR_DATA_READY
                       && BUS_WR_DATA_LAST;
    assign b_hs      = BUS_WR_BACK_VALID && BUS_WR_BACK_READY;

    always_comb begin
        cnt_d = cnt_q;
        if (aw_hs && !b_hs) begin
            if (cnt_q < MAX_Q) cnt_d = cnt_q + 8'd1;
        end else if (b_hs && !aw_hs) begin
            if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            addr_sel_q <= '0;
            data_sel_q <= '0;
            last_q     <= '1;
            grant_q    <= 1'b0;
            open_q     <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    // Registered count gates the grant, so a freed slot is usable one edge later.
                    if (pick_any && (cnt_q < MAX_Q)) begin
                        state_q    <= ADDR;
                        addr_sel_q <= pick_idx;
                        data_sel_q <= pick_idx;
                        last_q     <= pick_idx;
                        grant_q    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        state_q <= DATA;
                        grant_q <= 1'b0;
                        open_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_last_hs) begin
                        state_q <= IDLE;
                        open_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 1'b0;
                    open_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_addr_master_sel = addr_sel_q;
    assign wr_data_master_sel = data_sel_q;
    assign wr_grant_valid     = grant_q;
    assign wr_data_open       = open_q;
    assign wr_outstanding     = cnt_q;

endmodule

// File: tb/tb_axi_wr_rr_scheduler.sv
// Self-checking bench: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a transaction-level model.
module tb_axi_wr_rr_scheduler;

    localparam int MW   = 2;
    localparam int N    = 4;
    localparam int MAXO = 2;

    // Handshake bundle bit order: {awv, awr, wv, wr, wl, bv, br}
    localparam logic [6:0] HS_NONE = 7'b000_0000;
    localparam logic [6:0] HS_AW   = 7'b110_0000;
    localparam logic [6:0] HS_W    = 7'b001_1000;
    localparam logic [6:0] HS_WL   = 7'b001_1100;
    localparam logic [6:0] HS_B    = 7'b000_0011;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  req = '0;
    logic          awv = 1'b0, awr = 1'b0, wv = 1'b0, wr = 1'b0, wl = 1'b0;
    logic          bv = 1'b0, br = 1'b0;
    logic [MW-1:0] addr_sel, data_sel;
    logic          grant_valid, data_open;
    logic [7:0]    outstanding;

    int passed = 0;
    int total  = 0;

    axi_wr_rr_scheduler #(
        .M_WIDTH         (MW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .MASTER_WR_ADDR_VALID (req),
        .BUS_WR_ADDR_VALID    (awv),
        .BUS_WR_ADDR_READY    (awr),
        .BUS_WR_DATA_VALID    (wv),
        .BUS_WR_DATA_READY    (wr),
        .BUS_WR_DATA_LAST     (wl),
        .BUS_WR_BACK_VALID    (bv),
        .BUS_WR_BACK_READY    (br),
        .wr_addr_master_sel   (addr_sel),
        .wr_data_master_sel   (data_sel),
        .wr_grant_valid       (grant_valid),
        .wr_data_open         (data_open),
        .wr_outstanding       (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [6:0]   hs;
        int           gv;
        int           dop;
        int           sel;
        int           cnt;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk(input string tag, input int gv, input int dop, input int sel, input int cnt);
        check({tag, " grant_valid"}, int'(grant_valid), gv);
        check({tag, " data_open"}, int'(data_open), dop);
        check({tag, " addr_sel"}, int'(addr_sel), sel);
        check({tag, " data_sel"}, int'(data_sel), sel);
        check({tag, " outstanding"}, int'(outstanding), cnt);
    endtask

    // Called at a negedge: apply inputs, cross one active edge, return at the next negedge.
    task automatic drive(input logic [N-1:0] r, input logic [6:0] hs);
        req = r;
        {awv, awr, wv, wr, wl, bv, br} = hs;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        {awv, awr, wv, wr, wl, bv, br} = HS_NONE;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Transaction-level reference model
    int m_holder;   // granted master while a burst is open, -1 otherwise
    bit m_aw_done;  // address phase of the open burst accepted
    int m_cnt;
    int m_sel;
    int m_prio;     // first master searched on the next grant

    function automatic void model_reset();
        m_holder  = -1;
        m_aw_done = 1'b0;
        m_cnt     = 0;
        m_sel     = 0;
        m_prio    = 0;
    endfunction

    function automatic void model_step();
        bit aw_acc, w_end, b_acc;
        int win;
        aw_acc = (m_holder >= 0) && !m_aw_done && awv && awr;
        w_end  = (m_holder >= 0) && m_aw_done && wv && wr && wl;
        b_acc  = bv && br;
        win    = -1;
        if (m_holder < 0 && m_cnt < MAXO) begin
            for (int k = N - 1; k >= 0; k--)
                if (req[(m_prio + k) % N]) win = (m_prio + k) % N;
        end
        if (aw_acc && !b_acc && m_cnt < MAXO) m_cnt = m_cnt + 1;
        else if (b_acc && !aw_acc && m_cnt > 0) m_cnt = m_cnt - 1;
        if (win >= 0) begin
            m_holder  = win;
            m_aw_done = 1'b0;
            m_sel     = win;
            m_prio    = (win + 1) % N;
        end else if (aw_acc) begin
            m_aw_done = 1'b1;
        end else if (w_end) begin
            m_holder = -1;
        end
    endfunction

    initial begin
        tbl[0]  = '{4'hF, HS_NONE,     1, 0, 0, 0};
        tbl[1]  = '{4'hF, HS_WL,       1, 0, 0, 0};  // W LAST in ADDR is ignored
        tbl[2]  = '{4'hF, HS_AW,       0, 1, 0, 1};
        tbl[3]  = '{4'hF, HS_WL | HS_B, 0, 0, 0, 0};
        tbl[4]  = '{4'hF, HS_NONE,     1, 0, 1, 0};
        tbl[5]  = '{4'hF, HS_AW,       0, 1, 1, 1};
        tbl[6]  = '{4'hF, HS_WL | HS_B, 0, 0, 1, 0};
        tbl[7]  = '{4'hF, HS_NONE,     1, 0, 2, 0};
        tbl[8]  = '{4'hF, HS_AW,       0, 1, 2, 1};
        tbl[9]  = '{4'hF, HS_WL | HS_B, 0, 0, 2, 0};
        tbl[10] = '{4'hF, HS_NONE,     1, 0, 3, 0};
        tbl[11] = '{4'hF, HS_AW,       0, 1, 3, 1};
        tbl[12] = '{4'hF, HS_WL | HS_B, 0, 0, 3, 0};
        tbl[13] = '{4'hF, HS_NONE,     1, 0, 0, 0};
        tbl[14] = '{4'hF, HS_AW,       0, 1, 0, 1};
        tbl[15] = '{4'hF, HS_WL,       0, 0, 0, 1};
        tbl[16] = '{4'hF, HS_NONE,     1, 0, 1, 1};
        tbl[17] = '{4'hF, HS_AW | HS_B, 0, 1, 1, 1}; // AW and B together at count 1
        tbl[18] = '{4'hF, HS_WL,       0, 0, 1, 1};
        tbl[19] = '{4'h0, HS_B,        0, 0, 1, 0};
        tbl[20] = '{4'h0, HS_B,        0, 0, 1, 0};  // B at zero must not underflow
        tbl[21] = '{4'h0, HS_AW,       0, 0, 1, 0};  // AW outside ADDR ignored

        @(negedge clk);
        @(negedge clk);
        chk("reset", 0, 0, 0, 0);
        rstn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].req, tbl[i].hs);
            $display("vec %0d req=%b hs=%b -> gv=%0d dop=%0d sel=%0d cnt=%0d",
                     i, tbl[i].req, tbl[i].hs, grant_valid, data_open, addr_sel, outstanding);
            chk($sformatf("vec%0d", i), tbl[i].gv, tbl[i].dop, tbl[i].sel, tbl[i].cnt);
        end

        // Outstanding limit: two bursts accepted, no B, then a single B frees a slot
        drive(4'hF, HS_NONE); chk("lim grant2", 1, 0, 2, 0);
        drive(4'hF, HS_AW);   chk("lim aw2", 0, 1, 2, 1);
        drive(4'hF, HS_WL);   chk("lim w2", 0, 0, 2, 1);
        drive(4'hF, HS_NONE); chk("lim grant3", 1, 0, 3, 1);
        drive(4'hF, HS_AW);   chk("lim aw3", 0, 1, 3, 2);
        drive(4'hF, HS_WL);   chk("lim w3", 0, 0, 3, 2);
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, HS_NONE);
            chk($sformatf("lim hold%0d", i), 0, 0, 3, 2);
        end
        drive(4'hF, HS_B);    chk("lim b", 0, 0, 3, 1);
        drive(4'hF, HS_NONE); chk("lim regrant", 1, 0, 0, 1);
        drive(4'hF, HS_AW);   chk("lim aw0", 0, 1, 0, 2);
        drive(4'hF, HS_WL);   chk("lim w0", 0, 0, 0, 2);
        $display("seq outstanding-limit done");

        // Select stability: master 2 drops its request in ADDR, 4-beat burst
        do_reset();
        drive(4'b0100, HS_NONE); chk("stab grant", 1, 0, 2, 0);
        drive(4'b0000, HS_NONE); chk("stab drop", 1, 0, 2, 0);
        drive(4'b1011, HS_AW);   chk("stab aw", 0, 1, 2, 1);
        for (int b = 1; b <= 3; b++) begin
            drive(4'b1011, HS_W);
            chk($sformatf("stab beat%0d", b), 0, 1, 2, 1);
        end
        drive(4'b1011, HS_WL);   chk("stab beat4", 0, 0, 2, 1);
        drive(4'b1011, HS_NONE); chk("stab next", 1, 0, 3, 1);
        drive(4'b1011, HS_AW);   chk("stab next aw", 0, 1, 3, 2);
        drive(4'b1011, HS_W);    chk("rst beat1", 0, 1, 3, 2);
        $display("seq select-stability done");

        // Asynchronous reset during W beat 2
        req = 4'b1011;
        {awv, awr, wv, wr, wl, bv, br} = HS_W;
        #2 rstn = 1'b0;
        #1 chk("rst async", 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(4'b0110, HS_NONE); chk("rst first grant", 1, 0, 1, 0);
        $display("seq mid-burst reset done");

        // Random traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            chk($sformatf("rnd%0d", c), int'(m_holder >= 0 && !m_aw_done),
                int'(m_holder >= 0 && m_aw_done), m_sel, m_cnt);
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            awv = ($urandom_range(0, 2) != 0);
            awr = ($urandom_range(0, 2) != 0);
            wv  = ($urandom_range(0, 2) != 0);
            wr  = ($urandom_range(0, 2) != 0);
            wl  = ($urandom_range(0, 2) == 0);
            bv  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 1) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        $display("seq random traffic done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
